// File: rtl/pio_led_blink.sv
// Avalon-MM LED output PIO with atomic set/clear/toggle and per-bit hardware blink.
// Zero-wait-state slave: readdata is combinational, register updates land on the write edge.
module pio_led_blink #(
  parameter int          WIDTH        = 8,
  parameter logic [31:0] RESET_VALUE  = 32'h0,
  parameter int          PERIOD_W     = 24,
  parameter logic [31:0] PERIOD_RESET = 32'h0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_MODE   = 3'd1;
  localparam logic [2:0] ADDR_PERIOD = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;
  localparam logic [2:0] ADDR_TOGGLE = 3'd6;

  logic                we;
  logic [WIDTH-1:0]    data;
  logic [WIDTH-1:0]    mode;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] counter;
  logic                phase;
  logic [WIDTH-1:0]    wd_bits;
  logic                unused_wd;

  assign we        = chipselect & ~write_n;
  assign wd_bits   = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= RESET_VALUE[WIDTH-1:0];
      mode <= '0;
    end else if (we) begin
      case (address)
        ADDR_DATA:   data <= wd_bits;
        ADDR_MODE:   mode <= wd_bits;
        ADDR_OUTSET: data <= data | wd_bits;
        ADDR_OUTCLR: data <= data & ~wd_bits;
        ADDR_TOGGLE: data <= data ^ wd_bits;
        default:     ;
      endcase
    end
  end

  // A PERIOD write restarts the prescaler in the high phase, overriding any wrap on that edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period  <= PERIOD_RESET[PERIOD_W-1:0];
      counter <= '0;
      phase   <= 1'b1;
    end else if (we && address == ADDR_PERIOD) begin
      period  <= writedata[PERIOD_W-1:0];
      counter <= '0;
      phase   <= 1'b1;
    end else if (counter == period) begin
      counter <= '0;
      phase   <= ~phase;
    end else begin
      counter <= counter + PERIOD_W'(1);
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[WIDTH-1:0]    = data;
      ADDR_MODE:   readdata[WIDTH-1:0]    = mode;
      ADDR_PERIOD: readdata[PERIOD_W-1:0] = period;
      ADDR_STATUS: readdata[0]            = phase;
      default:     readdata = '0;
    endcase
  end

  assign out_port = data & (~mode | {WIDTH{phase}});

endmodule

// File: tb/tb_pio_led_blink.sv
// Directed bench for pio_led_blink: WIDTH=8, RESET_VALUE=A5, PERIOD_RESET=9.
module tb_pio_led_blink;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int checks = 0;
  int passed = 0;

  pio_led_blink #(
    .WIDTH(8), .RESET_VALUE(32'hA5), .PERIOD_W(24), .PERIOD_RESET(32'd9)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One write, committed on the next rising edge; returns 1ns after that edge.
  task automatic wr(input logic [2:0] a, input logic [31:0] v);
    @(negedge clk);
    address = a; writedata = v; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(tag, readdata, exp);
  endtask

  initial begin
    logic exp_phase;

    // Reset state observed while reset is held
    #12;
    chk("rst_out", {24'h0, out_port}, 32'hA5);
    rd("rst_data", 3'd0, 32'h0000_00A5);
    rd("rst_mode", 3'd1, 32'h0);
    rd("rst_period", 3'd2, 32'd9);
    rd("rst_status", 3'd3, 32'h1);
    @(negedge clk);
    reset_n = 1'b1;

    // Back-to-back full write and atomic ops; upper writedata bits must be ignored
    wr(3'd0, 32'hFFFF_FF0F); chk("wr_data", {24'h0, out_port}, 32'h0F);
    wr(3'd4, 32'hABCD_00F0); chk("outset",  {24'h0, out_port}, 32'hFF);
    wr(3'd5, 32'h1234_5611); chk("outclr",  {24'h0, out_port}, 32'hEE);
    wr(3'd6, 32'hFFFF_FF03); chk("toggle",  {24'h0, out_port}, 32'hED);
    rd("rd_data", 3'd0, 32'h0000_00ED);
    for (int a = 4; a < 8; a++) rd($sformatf("rd_wo_%0d", a), 3'(a), 32'h0);
    wr(3'd7, 32'hFFFF_FFFF); chk("rsvd_ignored", {24'h0, out_port}, 32'hED);

    // Blink, half-period 4: PERIOD write at E0, phase high after E0..E3, low after E4..E7
    wr(3'd2, 32'hFF00_0003);
    wr(3'd1, 32'h0000_0001);
    wr(3'd0, 32'h0000_0001);
    rd("rd_period3", 3'd2, 32'd3);
    rd("rd_mode1", 3'd1, 32'h1);
    address = 3'd3;
    for (int i = 0; i < 16; i++) begin
      if (i != 0) begin @(posedge clk); #1; end
      exp_phase = ((2 + i) % 8) < 4;
      chk($sformatf("blink4_out_%0d", i), {24'h0, out_port}, {31'h0, exp_phase});
      chk($sformatf("blink4_status_%0d", i), readdata, {31'h0, exp_phase});
    end

    // PERIOD=0: phase toggles every cycle; after the DATA write edge phase is high
    wr(3'd2, 32'h0);
    wr(3'd1, 32'hFF);
    wr(3'd0, 32'hFF);
    for (int i = 0; i < 6; i++) begin
      if (i != 0) begin @(posedge clk); #1; end
      chk($sformatf("blink1_out_%0d", i), {24'h0, out_port}, (i % 2 == 0) ? 32'hFF : 32'h00);
    end

    // PERIOD rewritten on the edge where counter==3: no toggle, next toggle 6 edges later
    wr(3'd2, 32'd3);
    repeat (3) @(posedge clk);
    #1;
    rd("pre_rewrite_status", 3'd3, 32'h1);
    wr(3'd2, 32'd5);
    rd("rd_period5", 3'd2, 32'd5);
    address = 3'd3;
    #1;
    for (int i = 0; i < 7; i++) begin
      if (i != 0) begin @(posedge clk); #1; end
      chk($sformatf("rewrite_out_%0d", i), {24'h0, out_port}, (i < 6) ? 32'hFF : 32'h00);
      chk($sformatf("rewrite_status_%0d", i), readdata, (i < 6) ? 32'h1 : 32'h0);
    end

    // Asynchronous reset between edges while blinking in the low phase
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_out", {24'h0, out_port}, 32'hA5);
    rd("arst_mode", 3'd1, 32'h0);
    rd("arst_period", 3'd2, 32'd9);
    rd("arst_status", 3'd3, 32'h1);
    @(negedge clk);
    reset_n = 1'b1;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
